// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the iterative multiply/divide unit.
package alu_pkg;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: right-shifting shift-add multiply
// or left-shifting restoring divide, on the {acc, q} register pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, opnd};
    rem  = {acc, q[WIDTH-1]};
    // Only consumed when rem >= opnd, so the result always fits in WIDTH bits.
    diff = rem[WIDTH-1:0] - opnd;
    // Explicit compare keeps b==0 well-behaved (acc may then exceed the divisor).
    ge   = (rem >= {1'b0, opnd});
    acc_next = acc;
    q_next   = q;
    if (is_div) begin
      acc_next = ge ? diff : rem[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], ge};
    end else if (q[0]) begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[WIDTH-1:1]};
      q_next   = {acc[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO, MTHI/MTLO,
// start/busy/done handshake, flush and divide-by-zero flag.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, opnd_q, opnd_d;
  logic [WIDTH-1:0]   aorig_q, aorig_d, hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   step_acc, step_q, mag_a, mag_b, quo, rmd;
  logic [2*WIDTH-1:0] prod;
  logic               sa, sb;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .q        (q_q),
    .opnd     (opnd_q),
    .acc_next (step_acc),
    .q_next   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      opnd_q    <= '0;
      aorig_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      opnd_q    <= opnd_d;
      aorig_q   <= aorig_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    sa    = op[0] & a[WIDTH-1];
    sb    = op[0] & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    prod  = neg_res_q ? -{acc_q, q_q} : {acc_q, q_q};
    quo   = neg_res_q ? -q_q : q_q;
    rmd   = neg_rem_q ? -acc_q : acc_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    opnd_d    = opnd_q;
    aorig_d   = aorig_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: begin
              hi_d  = a;
              dbz_d = 1'b0;
            end
            OP_MTLO: begin
              lo_d  = a;
              dbz_d = 1'b0;
            end
            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
              // The dividend/multiplier goes in q, the divisor/multiplicand in opnd.
              is_div_d  = op[1];
              acc_d     = '0;
              q_d       = op[1] ? mag_a : mag_b;
              opnd_d    = op[1] ? mag_b : mag_a;
              neg_res_d = sa ^ sb;
              neg_rem_d = sa;
              dz_d      = op[1] && (b == '0);
              aorig_d   = a;
              cnt_d     = '0;
              dbz_d     = 1'b0;
              state_d   = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          q_d   = step_q;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = aorig_q;
            lo_d = '1;
          end else begin
            hi_d = rmd;
            lo_d = quo;
          end
          dbz_d   = dz_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): vector table plus latency,
// flush, restart, MTHI/MTLO and asynchronous reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one op and returns at the negedge where done is high (or after a timeout).
  task automatic run_op(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
    bit got;
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("done_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    int n, busy_cnt, done_cnt;

    vecs[0]  = '{"multu_max",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{"mult_m3x7",   3'b001, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{"mult_minmin", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{"div_m7d2",    3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{"divu_64d7",   3'b010, 32'h00000040, 32'h00000007, 32'h00000001, 32'h00000009, 1'b0};
    vecs[5]  = '{"divu_by0",    3'b010, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{"multu_clr",   3'b000, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
    vecs[7]  = '{"div_ovf",     3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[8]  = '{"div_7dm2",    3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{"div_m7by0",   3'b011, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{"mult_m1m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[11] = '{"divu_maxd1",  3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b);
      $display("vec %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d", vecs[i].name, vecs[i].op,
               vecs[i].a, vecs[i].b, hi, lo, div_by_zero);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
      chk({vecs[i].name, "_dbz"}, 32'(div_by_zero), 32'(vecs[i].dbz));
    end

    // Latency: done on the 34th edge counting the start edge; busy for 33 cycles.
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk);
    n = 1; busy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    while (n < 100 && !done) begin
      busy_cnt += int'(busy);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    $display("latency multu: edges=%0d busy_cycles=%0d hi=%h lo=%h", n, busy_cnt, hi, lo);
    chk("lat_edges", 32'(n), 32'd34);
    chk("lat_busy", 32'(busy_cnt), 32'd33);
    chk("lat_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("lat_done_pulse", 32'(done), 32'd0);

    // Flush at count=10: no done, hi/lo keep FFFFFFFE/00000001.
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
    $display("flush: done_pulses=%0d hi=%h lo=%h", done_cnt, hi, lo);
    chk("flush_done", 32'(done_cnt), 32'd0);
    chk("flush_hi", hi, 32'hFFFFFFFE);
    chk("flush_lo", lo, 32'h00000001);

    // flush beats start in IDLE.
    start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    $display("flush+start: busy=%0d", busy);
    chk("flushpri_busy", 32'(busy), 32'd0);

    // A start mid-RUN is ignored: one done, result of the first op.
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
    $display("restart mid-run: done_pulses=%0d hi=%h lo=%h", done_cnt, hi, lo);
    chk("midrun_dones", 32'(done_cnt), 32'd1);
    chk("midrun_lo", lo, 32'h0000000F);

    // MTHI / MTLO: written at the next edge, no busy/done.
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    $display("mthi: hi=%h busy=%0d done=%0d", hi, busy, done);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", 32'(busy), 32'd0);
    start = 1'b1; op = 3'b101; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    done_cnt = int'(done);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
    $display("mtlo: lo=%h hi=%h done_pulses=%0d", lo, hi, done_cnt);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtx_done", 32'(done_cnt), 32'd0);

    // Undefined op is ignored.
    start = 1'b1; op = 3'b111; a = 32'h55555555; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    $display("undef op: busy=%0d hi=%h lo=%h", busy, hi, lo);
    chk("undef_busy", 32'(busy), 32'd0);
    chk("undef_lo", lo, 32'h9ABCDEF0);

    // Asynchronous reset at count=5, after a div-by-zero left nonzero state.
    run_op(3'b010, 32'h0000000A, 32'h0);
    chk("pre_rst_dbz", 32'(div_by_zero), 32'd1);
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("async rst: hi=%h lo=%h busy=%0d done=%0d dbz=%0d", hi, lo, busy, done, div_by_zero);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'b001, 32'hFFFFFFFD, 32'h00000007);
    $display("post-rst mult: hi=%h lo=%h", hi, lo);
    chk("postrst_lo", lo, 32'hFFFFFFEB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
